riscv_fetch_stage: RTL and testbench

- Fetch front end that consumes the hazard controller's stall/flush outputs: PC register, instruction-memory request/response handshake, one-entry hold buffer, IF/ID pipeline register.
- Sits between instruction memory and ID decode.
- Honours PC_stall, IFID_stall and IFID_flush, and applies branch redirects.
- Drops stale in-flight fetches after a redirect.

---
 rtl/riscv_fetch_stage_pkg.sv | 21 ++
 rtl/riscv_fetch_holdbuf.sv | 56 +++++
 rtl/riscv_fetch_stage.sv | 207 ++++++++++++++++++++
 tb/tb_riscv_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_stage_pkg.sv
// Shared constants and types for the RISC-V fetch front end: FSM state
// encoding, instruction width, default reset PC and bubble word.
package riscv_fetch_stage_pkg;

    localparam int unsigned ILEN                 = 32;
    localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_BUBBLE_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // may issue a request for pc
        S_WAIT = 2'd1,  // request granted, response outstanding
        S_HOLD = 2'd2,  // response parked because IF/ID was stalled
        S_KILL = 2'd3   // redirected while outstanding; drop next response
    } fetch_state_e;

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/riscv_fetch_holdbuf.sv
// One-entry {instr, pc} parking slot used when a response arrives while IF/ID
// is stalled. Outputs come straight from flops: a load shows up next cycle.
module riscv_fetch_holdbuf
    import riscv_fetch_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q, valid_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Next entry: load captures a word, drain or clear empties the slot.
    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (drain_i || clear_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage; only the valid flag needs a reset value.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        // NOTE: payload is not reset on purpose; valid_q qualifies every use of it.
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/riscv_fetch_stage.sv
// RISC-V fetch stage: PC register, single-outstanding instruction-memory
// handshake, one-entry hold buffer and IF/ID register. Honours the hazard
// unit's PC_stall/IFID_stall/IFID_flush and branch redirects, and drops stale
// responses after a redirect. Define FETCH_PERF_CNT_EN to build the
// saturating fetch/kill counters; otherwise both count ports read zero.
module riscv_fetch_stage
    import riscv_fetch_stage_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(DEFAULT_RESET_PC),
    parameter logic [ILEN-1:0] BUBBLE_INSTR = DEFAULT_BUBBLE_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            PC_stall_i,
    input  logic            IFID_stall_i,
    input  logic            IFID_flush_i,
    input  logic            Branch_taken_i,
    input  logic [XLEN-1:0] Branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic [ILEN-1:0] ID_instr_o,
    output logic [XLEN-1:0] ID_pc_o,
    output logic            ID_valid_o,
    output logic [31:0]     fetch_count_o,
    output logic [31:0]     kill_count_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [ILEN-1:0] ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic            ifid_valid_q, ifid_valid_d;

    logic            hb_load, hb_drain, hb_clear, hb_valid;
    logic [ILEN-1:0] hb_instr;
    logic [XLEN-1:0] hb_pc;
    logic            ifid_take_rsp, ifid_take_hb;
    logic [XLEN-1:0] target_aligned;

    assign target_aligned = Branch_target_i & ~XLEN'(3);

    // State, PC and IF/ID registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            ifid_instr_q <= BUBBLE_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Next state, PC update and hold-buffer control.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        hb_load       = 1'b0;
        hb_drain      = 1'b0;
        hb_clear      = 1'b0;
        ifid_take_rsp = 1'b0;
        case (state_q)
            S_REQ: begin
                if (Branch_taken_i) begin
                    pc_d = target_aligned;
                end else if (imem_req_o && imem_gnt_i) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + XLEN'(4);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                    if (Branch_taken_i) begin
                        pc_d = target_aligned;
                    end else if (IFID_flush_i || !IFID_stall_i) begin
                        ifid_take_rsp = !IFID_flush_i;
                    end else begin
                        hb_load = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (Branch_taken_i) begin
                    pc_d    = target_aligned;
                    state_d = S_KILL;
                end
            end
            S_HOLD: begin
                // The parked word is younger than any redirect or flush.
                if (Branch_taken_i || IFID_flush_i) begin
                    hb_clear = 1'b1;
                    state_d  = S_REQ;
                    if (Branch_taken_i) begin
                        pc_d = target_aligned;
                    end
                end else if (!IFID_stall_i) begin
                    hb_drain = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_KILL: begin
                if (Branch_taken_i) begin
                    pc_d = target_aligned;
                end
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Memory-side outputs; no request while reset is held.
    always_comb begin
        imem_req_o  = rst_n_i && (state_q == S_REQ) && !PC_stall_i && !Branch_taken_i;
        imem_addr_o = pc_q;
    end

    // IF/ID priority: flush > stall > response > hold buffer > bubble.
    always_comb begin
        ifid_take_hb = hb_drain && hb_valid;
        ifid_instr_d = BUBBLE_INSTR;
        ifid_pc_d    = '0;
        ifid_valid_d = 1'b0;
        if (IFID_flush_i) begin
            ifid_valid_d = 1'b0;
        end else if (IFID_stall_i) begin
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
            ifid_valid_d = ifid_valid_q;
        end else if (ifid_take_rsp) begin
            ifid_instr_d = imem_rdata_i;
            ifid_pc_d    = fetch_pc_q;
            ifid_valid_d = 1'b1;
        end else if (ifid_take_hb) begin
            ifid_instr_d = hb_instr;
            ifid_pc_d    = hb_pc;
            ifid_valid_d = 1'b1;
        end
    end

    riscv_fetch_holdbuf #(
        .XLEN (XLEN)
    ) u_holdbuf (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (hb_load),
        .drain_i (hb_drain),
        .clear_i (hb_clear),
        .instr_i (imem_rdata_i),
        .pc_i    (fetch_pc_q),
        .valid_o (hb_valid),
        .instr_o (hb_instr),
        .pc_o    (hb_pc)
    );

    assign ID_instr_o = ifid_instr_q;
    assign ID_pc_o    = ifid_pc_q;
    assign ID_valid_o = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_evt, kill_evt;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    // Count words entering IF/ID and every discarded response.
    always_comb begin
        fetch_evt   = ifid_take_rsp || ifid_take_hb;
        kill_evt    = hb_clear ||
                      (imem_rvalid_i && ((state_q == S_KILL) ||
                       ((state_q == S_WAIT) && (Branch_taken_i || IFID_flush_i))));
        fetch_cnt_d = fetch_evt ? sat_inc(fetch_cnt_q) : fetch_cnt_q;
        kill_cnt_d  = kill_evt  ? sat_inc(kill_cnt_q)  : kill_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fetch_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign kill_count_o  = kill_cnt_q;
`else
    assign fetch_count_o = '0;
    assign kill_count_o  = '0;
`endif

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage: a table of per-cycle vectors with
// hand-computed outputs, followed by a reset-during-S_WAIT sequence.
module tb_riscv_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] B     = 32'h0000_0000;
    localparam logic [31:0] D0    = 32'h0010_0093;
    localparam logic [31:0] D4    = 32'h0020_0113;
    localparam logic [31:0] D8    = 32'h0030_0193;
    localparam logic [31:0] DC    = 32'h0040_0213;
    localparam logic [31:0] D10   = 32'h0050_0293;
    localparam logic [31:0] D14   = 32'h0060_0313;
    localparam logic [31:0] D18   = 32'h0070_0393;
    localparam logic [31:0] D100  = 32'h0080_0413;
    localparam logic [31:0] D104  = 32'h0090_0493;
    localparam logic [31:0] D108  = 32'h00A0_0513;
    localparam logic [31:0] D2000 = 32'h00B0_0593;
    localparam logic [31:0] D3000 = 32'h00C0_0613;
    localparam logic [31:0] DFF   = 32'h00D0_0693;
    localparam logic [31:0] D0B   = 32'h00E0_0713;
    localparam logic [31:0] D500  = 32'h00F0_0793;

    logic        clk = 1'b0;
    logic        rst_n, pc_stall, ifid_stall, ifid_flush, br_taken;
    logic [31:0] br_target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] id_instr, id_pc;
    logic        id_valid;
    logic [31:0] fetch_count, kill_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    riscv_fetch_stage #(
        .XLEN         (32),
        .RESET_PC     (32'h0000_0000),
        .BUBBLE_INSTR (32'h0000_0000)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .PC_stall_i      (pc_stall),
        .IFID_stall_i    (ifid_stall),
        .IFID_flush_i    (ifid_flush),
        .Branch_taken_i  (br_taken),
        .Branch_target_i (br_target),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_gnt_i      (imem_gnt),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .ID_instr_o      (id_instr),
        .ID_pc_o         (id_pc),
        .ID_valid_o      (id_valid),
        .fetch_count_o   (fetch_count),
        .kill_count_o    (kill_count)
    );

    typedef struct {
        bit          rst_n, ps, is, fl, br;
        logic [31:0] tgt;
        bit          gnt, rv;
        logic [31:0] rdata;
        bit          req, ca;
        logic [31:0] addr, instr, pc;
        bit          valid;
        logic [31:0] fc, kc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst_n_v, input bit ps, input bit is, input bit fl, input bit br,
                       input logic [31:0] tgt, input bit gnt, input bit rv, input logic [31:0] rdata,
                       input bit req, input bit ca, input logic [31:0] addr,
                       input logic [31:0] instr, input logic [31:0] pc, input bit valid,
                       input logic [31:0] fc, input logic [31:0] kc);
        vec_t v;
        v.rst_n = rst_n_v; v.ps = ps; v.is = is; v.fl = fl; v.br = br; v.tgt = tgt;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.req = req; v.ca = ca; v.addr = addr;
        v.instr = instr; v.pc = pc; v.valid = valid; v.fc = fc; v.kc = kc;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit r, input bit ps, input bit is, input bit fl, input bit br,
                         input logic [31:0] tgt, input bit gnt, input bit rv, input logic [31:0] rdata);
        rst_n = r; pc_stall = ps; ifid_stall = is; ifid_flush = fl; br_taken = br;
        br_target = tgt; imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
    endtask

    task automatic check_id(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input bit valid, input logic [31:0] fc, input logic [31:0] kc);
        check({tag, " ID_instr"}, id_instr, instr);
        check({tag, " ID_pc"}, id_pc, pc);
        check({tag, " ID_valid"}, 32'(id_valid), 32'(valid));
        check({tag, " fetch_count"}, fetch_count, PERF ? fc : 32'd0);
        check({tag, " kill_count"}, kill_count, PERF ? kc : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);

        // rst ps is fl br tgt | gnt rv rdata | req ca addr | instr pc valid | fc kc
        add(0,0,0,0,0,32'h0,          0,0,32'h0,  0,0,32'h0,          B,32'h0,0,            0,0);
        add(0,0,0,0,0,32'h0,          1,0,32'h0,  0,1,32'h0,          B,32'h0,0,            0,0);
        // back-to-back fetches 0x0, 0x4, 0x8 with gnt held high
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h0,          B,32'h0,0,            0,0);
        add(1,0,0,0,0,32'h0,          1,1,D0,     0,0,32'h0,          D0,32'h0,1,           1,0);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h4,          B,32'h0,0,            1,0);
        add(1,0,0,0,0,32'h0,          1,1,D4,     0,0,32'h0,          D4,32'h4,1,           2,0);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h8,          B,32'h0,0,            2,0);
        add(1,0,0,0,0,32'h0,          1,1,D8,     0,0,32'h0,          D8,32'h8,1,           3,0);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'hC,          B,32'h0,0,            3,0);
        add(1,0,0,0,0,32'h0,          1,1,DC,     0,0,32'h0,          DC,32'hC,1,           4,0);
        // IF/ID stalled 3 cycles while the 0x10 response lands in the hold buffer
        add(1,0,1,0,0,32'h0,          1,0,32'h0,  1,1,32'h10,         DC,32'hC,1,           4,0);
        add(1,0,1,0,0,32'h0,          1,1,D10,    0,0,32'h0,          DC,32'hC,1,           4,0);
        add(1,0,1,0,0,32'h0,          1,0,32'h0,  0,0,32'h0,          DC,32'hC,1,           4,0);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  0,0,32'h0,          D10,32'h10,1,         5,0);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h14,         B,32'h0,0,            5,0);
        add(1,0,0,0,0,32'h0,          1,1,D14,    0,0,32'h0,          D14,32'h14,1,         6,0);
        // redirect to 0x103 while waiting: stale 0x18 word dropped, refetch at 0x100
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h18,         B,32'h0,0,            6,0);
        add(1,0,0,0,1,32'h103,        1,0,32'h0,  0,0,32'h0,          B,32'h0,0,            6,0);
        add(1,0,0,0,0,32'h0,          1,1,D18,    0,0,32'h0,          B,32'h0,0,            6,1);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h100,        B,32'h0,0,            6,1);
        add(1,0,0,0,0,32'h0,          1,1,D100,   0,0,32'h0,          D100,32'h100,1,       7,1);
        // flush and stall together with rvalid: bubble wins, response dropped
        add(1,0,1,0,0,32'h0,          1,0,32'h0,  1,1,32'h104,        D100,32'h100,1,       7,1);
        add(1,0,1,1,0,32'h0,          1,1,D104,   0,0,32'h0,          B,32'h0,0,            7,2);
        // PC_stall for 4 cycles in S_REQ, then resume at the same address
        add(1,1,0,0,0,32'h0,          1,0,32'h0,  0,1,32'h108,        B,32'h0,0,            7,2);
        add(1,1,0,0,0,32'h0,          1,0,32'h0,  0,1,32'h108,        B,32'h0,0,            7,2);
        add(1,1,0,0,0,32'h0,          1,0,32'h0,  0,1,32'h108,        B,32'h0,0,            7,2);
        add(1,1,0,0,0,32'h0,          1,0,32'h0,  0,1,32'h108,        B,32'h0,0,            7,2);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h108,        B,32'h0,0,            7,2);
        add(1,0,0,0,0,32'h0,          1,1,D108,   0,0,32'h0,          D108,32'h108,1,       8,2);
        // redirect under PC_stall, then same-cycle redirect with rvalid
        add(1,1,0,0,1,32'h2002,       1,0,32'h0,  0,1,32'h10C,        B,32'h0,0,            8,2);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h2000,       B,32'h0,0,            8,2);
        add(1,0,0,0,1,32'h3000,       1,1,D2000,  0,0,32'h0,          B,32'h0,0,            8,3);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h3000,       B,32'h0,0,            8,3);
        // S_WAIT -> S_KILL, second redirect in S_KILL, then PC wraps past 2^32
        add(1,0,0,0,1,32'h4000,       1,0,32'h0,  0,0,32'h0,          B,32'h0,0,            8,3);
        add(1,0,0,0,1,32'hFFFF_FFFF,  1,0,32'h0,  0,0,32'h0,          B,32'h0,0,            8,3);
        add(1,0,0,0,0,32'h0,          1,1,D3000,  0,0,32'h0,          B,32'h0,0,            8,4);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'hFFFF_FFFC,  B,32'h0,0,            8,4);
        add(1,0,0,0,0,32'h0,          1,1,DFF,    0,0,32'h0,          DFF,32'hFFFF_FFFC,1,  9,4);
        add(1,0,0,0,0,32'h0,          0,0,32'h0,  1,1,32'h0,          B,32'h0,0,            9,4);
        // parked word discarded by a redirect in S_HOLD
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h0,          B,32'h0,0,            9,4);
        add(1,0,1,0,0,32'h0,          1,1,D0B,    0,0,32'h0,          B,32'h0,0,            9,4);
        add(1,0,1,0,1,32'h500,        1,0,32'h0,  0,0,32'h0,          B,32'h0,0,            9,5);
        add(1,0,0,0,0,32'h0,          1,0,32'h0,  1,1,32'h500,        B,32'h0,0,            9,5);
        add(1,0,0,0,0,32'h0,          1,1,D500,   0,0,32'h0,          D500,32'h500,1,       10,5);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].ps, vecs[i].is, vecs[i].fl, vecs[i].br, vecs[i].tgt,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            #1;
            check($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].ca) begin
                check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
            end
            @(posedge clk);
            #1;
            check_id($sformatf("v%0d", i), vecs[i].instr, vecs[i].pc, vecs[i].valid,
                     vecs[i].fc, vecs[i].kc);
        end

        // Reset while a request to 0x504 is outstanding; its late response is ignored.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        #1;
        check("rst_seq req_0x504", 32'(imem_req), 32'd1);
        check("rst_seq addr_0x504", imem_addr, 32'h504);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        check("rst_seq req_in_reset", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        check_id("rst_seq after_reset", B, 32'h0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        #1;
        check("rst_seq first_req", 32'(imem_req), 32'd1);
        check("rst_seq first_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        check_id("rst_seq stale_rvalid", B, 32'h0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        #1;
        check("rst_seq refetch_req", 32'(imem_req), 32'd1);
        check("rst_seq refetch_addr", imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h0, 0, 1, D10);
        @(posedge clk);
        #1;
        check_id("rst_seq refetch_data", D10, 32'h0, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
